ibex_tl_bridge: RTL and testbench

IBEX_TL_BRIDGE -- requirements
Module: ibex_tl_bridge

---
 rtl/ibex_tl_pkg.sv | 40 ++++
 rtl/ibex_tl_bridge_fifo.sv | 68 ++++++
 rtl/ibex_tl_bridge.sv | 153 +++++++++++++++
 tb/tb_ibex_tl_bridge.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_tl_pkg.sv
// rtl/ibex_tl_pkg.sv - TL-UL opcode constants and A/D channel field widths
//
// Shared by the Ibex-to-TL-UL bridge and its sub-modules.
// Contents: A/D field widths, A-channel opcodes (Get, PutFullData,
// PutPartialData), D-channel opcodes (AccessAck, AccessAckData) and a helper
// that selects the A opcode from the core's write enable and byte enables.

package ibex_tl_pkg;

  localparam int TL_OPCODE_W = 3;
  localparam int TL_PARAM_W  = 3;
  localparam int TL_SIZE_W   = 2;
  localparam int TL_SOURCE_W = 8;
  localparam int TL_ADDR_W   = 32;
  localparam int TL_MASK_W   = 4;
  localparam int TL_DATA_W   = 32;

  typedef enum logic [TL_OPCODE_W-1:0] {
    TL_PUT_FULL_DATA    = 3'd0,
    TL_PUT_PARTIAL_DATA = 3'd1,
    TL_GET              = 3'd4
  } tl_a_op_e;

  typedef enum logic [TL_OPCODE_W-1:0] {
    TL_ACCESS_ACK      = 3'd0,
    TL_ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  // A full-word write is PutFullData; any write with a byte hole is partial.
  function automatic tl_a_op_e tl_a_opcode(input logic we, input logic [TL_MASK_W-1:0] be);
    if (!we) begin
      return TL_GET;
    end else if (be == 4'hF) begin
      return TL_PUT_FULL_DATA;
    end else begin
      return TL_PUT_PARTIAL_DATA;
    end
  endfunction

endpackage

// File: rtl/ibex_tl_bridge_fifo.sv
// rtl/ibex_tl_bridge_fifo.sv - in-order 1-bit request-type FIFO
//
// Ports:
//   clock, reset        sole clock, synchronous active-high reset
//   push, push_data     enqueue one entry (ignored when full)
//   pop                 dequeue the head entry (ignored when empty)
//   pop_data            current head entry
//   full, empty         occupancy flags

module ibex_tl_bridge_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic pop_data,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (cnt == DEPTH_C);
  assign empty    = (cnt == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Entry storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        cnt <= cnt + 1'b1;
      end else if (!push_ok && pop_ok) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ibex_tl_bridge.sv
// rtl/ibex_tl_bridge.sv - Ibex core data bus to TL-UL host bridge
//
// Optional feature macro: IBEX_TL_BRIDGE_PROTO_CHECK_EN (D-channel opcode /
// source checking and sticky io_protocol_err_o; tied off when undefined).
//
// Ports:
//   clock, reset                 sole clock, synchronous active-high reset
//   io_req_i .. io_wdata_i       core request side (req/we/be/addr/wdata)
//   io_gnt_o                     request accepted this cycle
//   io_rvalid_o/rdata_o/err_o    registered response, one per granted request
//   io_a_*                       TL-UL A channel (host -> device)
//   io_d_*                       TL-UL D channel (device -> host)
//   io_protocol_err_o            sticky protocol-violation flag

module ibex_tl_bridge
  import ibex_tl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int SOURCE_ID       = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_req_i,
  output logic                   io_gnt_o,
  output logic                   io_rvalid_o,
  input  logic                   io_we_i,
  input  logic [TL_MASK_W-1:0]   io_be_i,
  input  logic [TL_ADDR_W-1:0]   io_addr_i,
  input  logic [TL_DATA_W-1:0]   io_wdata_i,
  output logic [TL_DATA_W-1:0]   io_rdata_o,
  output logic                   io_err_o,
  output logic                   io_a_valid_o,
  input  logic                   io_a_ready_i,
  output logic [TL_OPCODE_W-1:0] io_a_opcode_o,
  output logic [TL_PARAM_W-1:0]  io_a_param_o,
  output logic [TL_SIZE_W-1:0]   io_a_size_o,
  output logic [TL_SOURCE_W-1:0] io_a_source_o,
  output logic [TL_ADDR_W-1:0]   io_a_address_o,
  output logic [TL_MASK_W-1:0]   io_a_mask_o,
  output logic [TL_DATA_W-1:0]   io_a_data_o,
  input  logic                   io_d_valid_i,
  output logic                   io_d_ready_o,
  input  logic [TL_OPCODE_W-1:0] io_d_opcode_i,
  input  logic [TL_SOURCE_W-1:0] io_d_source_i,
  input  logic [TL_DATA_W-1:0]   io_d_data_i,
  input  logic                   io_d_denied_i,
  output logic                   io_protocol_err_o
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  logic [2:0]           count;
  logic                 gnt;
  logic                 d_accept;
  logic                 head_is_write;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 unused_fifo_flags;
  logic                 proto_mismatch;
  logic                 rvalid_q;
  logic                 err_q;
  logic [TL_DATA_W-1:0] rdata_q;

  // A channel: valid only while a slot is free; the count is registered so a
  // slot freed by this cycle's response is not reusable until the next cycle.
  assign io_a_valid_o   = io_req_i && (count < MAX_CNT);
  assign gnt            = io_a_valid_o && io_a_ready_i;
  assign io_gnt_o       = gnt;
  assign io_a_opcode_o  = tl_a_opcode(io_we_i, io_be_i);
  assign io_a_param_o   = '0;
  assign io_a_size_o    = 2'd2;
  assign io_a_source_o  = TL_SOURCE_W'(SOURCE_ID);
  assign io_a_address_o = io_addr_i;
  assign io_a_mask_o    = io_be_i;
  assign io_a_data_o    = io_wdata_i;

  // D channel is always accepted; beats with nothing outstanding are dropped.
  assign io_d_ready_o = 1'b1;
  assign d_accept     = io_d_valid_i && (count != '0);

  ibex_tl_bridge_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_type_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (gnt),
    .push_data(io_we_i),
    .pop      (d_accept),
    .pop_data (head_is_write),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Occupancy is tracked by count; the FIFO flags mirror it.
  assign unused_fifo_flags = fifo_full ^ fifo_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (gnt && !d_accept) begin
      count <= count + 3'd1;
    end else if (!gnt && d_accept) begin
      count <= count - 3'd1;
    end
  end

`ifdef IBEX_TL_BRIDGE_PROTO_CHECK_EN
  logic             proto_err_q;
  logic             d_drop;
  tl_d_op_e         exp_d_op;

  assign exp_d_op       = head_is_write ? TL_ACCESS_ACK : TL_ACCESS_ACK_DATA;
  assign proto_mismatch = (io_d_opcode_i != exp_d_op) ||
                          (io_d_source_i != TL_SOURCE_W'(SOURCE_ID));
  assign d_drop         = io_d_valid_i && (count == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      proto_err_q <= 1'b0;
    end else if ((d_accept && proto_mismatch) || d_drop) begin
      proto_err_q <= 1'b1;
    end
  end

  assign io_protocol_err_o = proto_err_q;
`else
  logic unused_d_fields;

  assign proto_mismatch    = 1'b0;
  assign unused_d_fields   = ^{io_d_opcode_i, io_d_source_i};
  assign io_protocol_err_o = 1'b0;
`endif

  // Response register: writes return zero data; rdata/err hold between beats.
  always_ff @(posedge clock) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= d_accept;
      if (d_accept) begin
        err_q   <= io_d_denied_i || proto_mismatch;
        rdata_q <= head_is_write ? '0 : io_d_data_i;
      end
    end
  end

  assign io_rvalid_o = rvalid_q;
  assign io_err_o    = err_q;
  assign io_rdata_o  = rdata_q;

endmodule

// File: tb/tb_ibex_tl_bridge.sv
// tb/tb_ibex_tl_bridge.sv - directed self-checking bench for ibex_tl_bridge

module tb_ibex_tl_bridge;

`ifdef IBEX_TL_BRIDGE_PROTO_CHECK_EN
  localparam logic PROTO = 1'b1;
`else
  localparam logic PROTO = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        io_req_i;
  logic        io_gnt_o;
  logic        io_rvalid_o;
  logic        io_we_i;
  logic [3:0]  io_be_i;
  logic [31:0] io_addr_i;
  logic [31:0] io_wdata_i;
  logic [31:0] io_rdata_o;
  logic        io_err_o;
  logic        io_a_valid_o;
  logic        io_a_ready_i;
  logic [2:0]  io_a_opcode_o;
  logic [2:0]  io_a_param_o;
  logic [1:0]  io_a_size_o;
  logic [7:0]  io_a_source_o;
  logic [31:0] io_a_address_o;
  logic [3:0]  io_a_mask_o;
  logic [31:0] io_a_data_o;
  logic        io_d_valid_i;
  logic        io_d_ready_o;
  logic [2:0]  io_d_opcode_i;
  logic [7:0]  io_d_source_i;
  logic [31:0] io_d_data_i;
  logic        io_d_denied_i;
  logic        io_protocol_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  ibex_tl_bridge #(
    .MAX_OUTSTANDING(2),
    .SOURCE_ID      (0)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .io_req_i         (io_req_i),
    .io_gnt_o         (io_gnt_o),
    .io_rvalid_o      (io_rvalid_o),
    .io_we_i          (io_we_i),
    .io_be_i          (io_be_i),
    .io_addr_i        (io_addr_i),
    .io_wdata_i       (io_wdata_i),
    .io_rdata_o       (io_rdata_o),
    .io_err_o         (io_err_o),
    .io_a_valid_o     (io_a_valid_o),
    .io_a_ready_i     (io_a_ready_i),
    .io_a_opcode_o    (io_a_opcode_o),
    .io_a_param_o     (io_a_param_o),
    .io_a_size_o      (io_a_size_o),
    .io_a_source_o    (io_a_source_o),
    .io_a_address_o   (io_a_address_o),
    .io_a_mask_o      (io_a_mask_o),
    .io_a_data_o      (io_a_data_o),
    .io_d_valid_i     (io_d_valid_i),
    .io_d_ready_o     (io_d_ready_o),
    .io_d_opcode_i    (io_d_opcode_i),
    .io_d_source_i    (io_d_source_i),
    .io_d_data_i      (io_d_data_i),
    .io_d_denied_i    (io_d_denied_i),
    .io_protocol_err_o(io_protocol_err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic d_beat(input logic [2:0] op, input logic [31:0] data, input logic denied,
                        input logic [7:0] src);
    io_d_valid_i  = 1'b1;
    io_d_opcode_i = op;
    io_d_data_i   = data;
    io_d_denied_i = denied;
    io_d_source_i = src;
  endtask

  task automatic d_idle();
    io_d_valid_i  = 1'b0;
    io_d_denied_i = 1'b0;
    io_d_source_i = 8'd0;
  endtask

  initial begin
    reset        = 1'b1;
    io_req_i     = 1'b0;
    io_we_i      = 1'b0;
    io_be_i      = 4'hF;
    io_addr_i    = 32'h0;
    io_wdata_i   = 32'h0;
    io_a_ready_i = 1'b1;
    io_d_opcode_i = 3'd0;
    io_d_data_i   = 32'h0;
    d_idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("reset_rvalid", io_rvalid_o, 0);
    check("reset_err", io_err_o, 0);
    check("reset_rdata", io_rdata_o, 0);
    check("reset_proto_err", io_protocol_err_o, 0);
    check("idle_a_valid", io_a_valid_o, 0);
    check("d_ready", io_d_ready_o, 1);

    // Single read
    io_req_i  = 1'b1;
    io_we_i   = 1'b0;
    io_addr_i = 32'h1000;
    io_be_i   = 4'hF;
    #1;
    check("rd_gnt", io_gnt_o, 1);
    check("rd_opcode", io_a_opcode_o, 4);
    check("rd_address", io_a_address_o, 32'h1000);
    check("rd_size", io_a_size_o, 2);
    check("rd_param", io_a_param_o, 0);
    check("rd_source", io_a_source_o, 0);
    tick();
    io_req_i = 1'b0;
    d_beat(3'd1, 32'hDEADBEEF, 1'b0, 8'd0);
    #1;
    check("rd_rvalid_not_early", io_rvalid_o, 0);
    tick();
    d_idle();
    check("rd_rvalid", io_rvalid_o, 1);
    check("rd_rdata", io_rdata_o, 32'hDEADBEEF);
    check("rd_err", io_err_o, 0);
    tick();
    check("rd_rvalid_one_cycle", io_rvalid_o, 0);

    // Partial write
    io_req_i   = 1'b1;
    io_we_i    = 1'b1;
    io_be_i    = 4'h3;
    io_addr_i  = 32'h2004;
    io_wdata_i = 32'h12345678;
    #1;
    check("pw_opcode", io_a_opcode_o, 1);
    check("pw_mask", io_a_mask_o, 4'h3);
    check("pw_data", io_a_data_o, 32'h12345678);
    check("pw_gnt", io_gnt_o, 1);
    tick();
    io_req_i = 1'b0;
    d_beat(3'd0, 32'hFFFFFFFF, 1'b0, 8'd0);
    tick();
    d_idle();
    check("pw_rvalid", io_rvalid_o, 1);
    check("pw_rdata_zero", io_rdata_o, 0);
    check("pw_err", io_err_o, 0);

    // Full write offered while A is not ready: no grant, nothing pushed
    io_req_i     = 1'b1;
    io_be_i      = 4'hF;
    io_a_ready_i = 1'b0;
    #1;
    check("fw_opcode", io_a_opcode_o, 0);
    check("fw_a_valid", io_a_valid_o, 1);
    check("fw_no_gnt", io_gnt_o, 0);
    tick();
    io_a_ready_i = 1'b1;

    // Back-to-back reads with D withheld
    io_we_i = 1'b0;
    #1;
    check("b2b_gnt1", io_gnt_o, 1);
    tick();
    check("b2b_gnt2", io_gnt_o, 1);
    tick();
    check("b2b_full_a_valid", io_a_valid_o, 0);
    check("b2b_full_gnt", io_gnt_o, 0);
    d_beat(3'd1, 32'h55, 1'b0, 8'd0);
    #1;
    check("b2b_no_bypass", io_a_valid_o, 0);
    tick();
    d_idle();
    check("b2b_rvalid", io_rvalid_o, 1);
    check("b2b_rdata", io_rdata_o, 32'h55);
    check("b2b_gnt3", io_gnt_o, 1);
    tick();
    io_req_i = 1'b0;

    // Denied response, then drain to zero
    d_beat(3'd1, 32'hAA, 1'b1, 8'd0);
    tick();
    check("denied_rvalid", io_rvalid_o, 1);
    check("denied_err", io_err_o, 1);
    check("denied_rdata", io_rdata_o, 32'hAA);
    d_beat(3'd1, 32'hBB, 1'b0, 8'd0);
    tick();
    check("drain_err", io_err_o, 0);
    check("drain_rdata", io_rdata_o, 32'hBB);

    // Beat with nothing outstanding is dropped
    d_beat(3'd1, 32'h66, 1'b0, 8'd0);
    tick();
    d_idle();
    check("drop_rvalid", io_rvalid_o, 0);
    check("drop_proto_err", io_protocol_err_o, PROTO);

    // Grant and response in the same cycle keep the count
    io_req_i = 1'b1;
    tick();
    d_beat(3'd1, 32'h77, 1'b0, 8'd0);
    #1;
    check("conc_gnt", io_gnt_o, 1);
    tick();
    d_idle();
    check("conc_rvalid", io_rvalid_o, 1);
    check("conc_rdata", io_rdata_o, 32'h77);
    check("conc_gnt_next", io_gnt_o, 1);
    tick();
    check("conc_full", io_a_valid_o, 0);
    io_req_i = 1'b0;
    d_beat(3'd1, 32'h1, 1'b0, 8'd0);
    tick();
    d_beat(3'd1, 32'h2, 1'b0, 8'd0);
    tick();
    d_idle();

    // Write answered with AccessAckData
    io_req_i = 1'b1;
    io_we_i  = 1'b1;
    tick();
    io_req_i = 1'b0;
    d_beat(3'd1, 32'hCAFE, 1'b0, 8'd0);
    tick();
    d_idle();
    check("wr_ackdata_rvalid", io_rvalid_o, 1);
    check("wr_ackdata_rdata", io_rdata_o, 0);
    check("wr_ackdata_err", io_err_o, PROTO);
    check("wr_ackdata_proto_err", io_protocol_err_o, PROTO);
    tick();
    check("proto_err_sticky", io_protocol_err_o, PROTO);

    // Read answered with a foreign source id
    io_req_i = 1'b1;
    io_we_i  = 1'b0;
    tick();
    io_req_i = 1'b0;
    d_beat(3'd1, 32'h99, 1'b0, 8'd5);
    tick();
    d_idle();
    check("src_rvalid", io_rvalid_o, 1);
    check("src_rdata", io_rdata_o, 32'h99);
    check("src_err", io_err_o, PROTO);

    // Reset with two outstanding
    io_req_i = 1'b1;
    tick();
    tick();
    io_req_i = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_rvalid", io_rvalid_o, 0);
    check("rst_err", io_err_o, 0);
    check("rst_rdata", io_rdata_o, 0);
    check("rst_proto_err", io_protocol_err_o, 0);
    d_beat(3'd1, 32'h44, 1'b0, 8'd0);
    tick();
    d_idle();
    check("stale_rvalid", io_rvalid_o, 0);
    check("stale_proto_err", io_protocol_err_o, PROTO);
    io_req_i = 1'b1;
    #1;
    check("post_rst_gnt", io_gnt_o, 1);
    tick();
    tick();
    check("post_rst_full", io_a_valid_o, 0);
    io_req_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
